// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_e        : loader FSM states
//   LEN_BYTES      : bytes in the big-endian word-count header
//   BYTES_PER_WORD : stream bytes per instruction word
//   ADDR_STEP      : byte-address increment between consecutive words
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_STEP      = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the loader, its byte-stream source and the instruction memory.
//   start      : one-cycle pulse requesting a new load
//   byte_in    : stream byte, qualified by byte_valid
//   byte_valid : byte_in valid
//   byte_ready : loader accepts byte_in (transfer = byte_valid & byte_ready at clk edge)
//   wr_en      : instruction-memory write strobe, one cycle per word
//   wr_addr    : byte address of the write
//   wr_data    : instruction word
//   cpu_hold   : 1 keeps the datapath stalled
//   done/error : image loaded / image rejected
// Modports: slave = the loader, master = stream source plus memory/CPU observer.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned AW = 32
) ();

  logic                        start;
  logic [7:0]                  byte_in;
  logic                        byte_valid;
  logic                        byte_ready;
  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [8*BYTES_PER_WORD-1:0] wr_data;
  logic                        cpu_hold;
  logic                        done;
  logic                        error;

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

endinterface

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart at byte index 0
//   load       : accept byte_in this cycle
//   byte_in    : stream byte
//   word       : assembled word including the byte currently offered (MSB first)
//   word_done  : load of the last byte of a word this cycle
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        load,
  input  logic [7:0]                  byte_in,
  output logic [8*BYTES_PER_WORD-1:0] word,
  output logic                        word_done
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);

  // Only the earlier bytes of a word need storage; the final byte is taken straight from byte_in.
  logic [8*(BYTES_PER_WORD-1)-1:0] shift_q;
  logic [IdxW-1:0]                 idx_q;

  assign word      = {shift_q, byte_in};
  assign word_done = load && (idx_q == IdxW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      shift_q <= word[8*(BYTES_PER_WORD-1)-1:0];
      idx_q   <= word_done ? '0 : idx_q + IdxW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream, packs it big-endian into
// words, writes them from BASE_ADDR upward and releases the CPU once the image is complete.
// Stream: LEN_HI, LEN_LO (word count N), 4*N data bytes [, CHK byte].
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imem_loader_if.slave (stream handshake, memory write port, status)
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append an XOR checksum byte to the stream;
// a mismatch rejects the image (words already written stay written).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned   MAX_WORDS = 256
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  localparam int unsigned LenW = 8 * LEN_BYTES;
  localparam int unsigned WordW = 8 * BYTES_PER_WORD;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e StAfterData = StChk;
`else
  localparam state_e StAfterData = StDone;
`endif

  state_e            state_q, state_d;
  logic              xfer;
  logic              restart;
  logic              len_load;
  logic              data_load;
  logic              word_done;
  logic              last_word;
  logic [WordW-1:0]  word;
  logic [7:0]        len_hi_q;
  logic [LenW-1:0]   len_next;
  logic [LenW-1:0]   len_q;
  logic [LenW-1:0]   word_cnt_q;
  logic              wr_en_q;
  logic [AW-1:0]     wr_addr_q;
  logic [WordW-1:0]  wr_data_q;

  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign data_load = xfer && (state_q == StData);
  assign len_next  = {len_hi_q, bus.byte_in};
  assign last_word = (word_cnt_q == len_q - LenW'(1));

  imem_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (len_load),
    .load      (data_load),
    .byte_in   (bus.byte_in),
    .word      (word),
    .word_done (word_done)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;

  // Every stream byte before the checksum byte itself contributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= '0;
    end else if (restart) begin
      chk_q <= '0;
    end else if (xfer && (state_q != StChk)) begin
      chk_q <= chk_q ^ bus.byte_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    len_load = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (bus.start) begin
          state_d = StLenHi;
          restart = 1'b1;
        end
      end
      StLenHi: begin
        if (xfer) state_d = StLenLo;
      end
      StLenLo: begin
        if (xfer) begin
          len_load = 1'b1;
          if (len_next == '0) begin
            state_d = StAfterData;
          end else if (32'(len_next) > MAX_WORDS) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (word_done && last_word) state_d = StAfterData;
      end
      StChk: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer) state_d = (bus.byte_in == chk_q) ? StDone : StErr;
`else
        state_d = StErr;
`endif
      end
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= '0;
    end else begin
      wr_en_q <= word_done;
      if (word_done) wr_data_q <= word;
      // wr_addr_q names the word being written while wr_en is high, then steps past it.
      if (restart) begin
        wr_addr_q <= BASE_ADDR;
      end else if (wr_en_q) begin
        wr_addr_q <= wr_addr_q + AW'(ADDR_STEP);
      end
      if (xfer && (state_q == StLenHi)) len_hi_q <= bus.byte_in;
      if (len_load) begin
        len_q      <= len_next;
        word_cnt_q <= '0;
      end else if (word_done) begin
        word_cnt_q <= word_cnt_q + LenW'(1);
      end
    end
  end

  assign bus.byte_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                          (state_q == StData)  || (state_q == StChk);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.done       = (state_q == StDone);
  assign bus.error      = (state_q == StErr);
  assign bus.cpu_hold   = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-index based reference model predicts ready,
// status and every memory write; directed images pin the model with literal expectations,
// then randomized images (gaps, stray starts, over-length headers) run against the model.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;  // near the top so addresses wrap
  localparam int unsigned MAXW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.AW(32)) bus ();

  imem_loader #(
    .AW        (32),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] wlog[$];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: status plus the index of the next stream byte within the current load.
  bit          m_busy, m_chk, m_wr;
  int          m_stat;  // 0 idle, 1 done, 2 rejected
  int          m_cnt;
  logic [15:0] m_n;
  logic [7:0]  m_hi, m_x;
  logic [31:0] m_word, m_wa, m_wd;

  task automatic finish_data();
`ifdef IMEM_LOADER_CHECKSUM_EN
    m_chk = 1'b1;
`else
    m_busy = 1'b0;
    m_stat = 1;
`endif
  endtask

  task automatic accept(input logic [7:0] b);
    int pos;
    int d;
    pos = m_cnt;
    m_cnt++;
    if (m_chk) begin
      m_busy = 1'b0;
      m_stat = (b == m_x) ? 1 : 2;
      return;
    end
    m_x = m_x ^ b;
    if (pos == 0) begin
      m_hi = b;
    end else if (pos == 1) begin
      m_n = {m_hi, b};
      if (m_n == 16'd0) finish_data();
      else if (32'(m_n) > MAXW) begin
        m_busy = 1'b0;
        m_stat = 2;
      end
    end else begin
      d = pos - 2;
      m_word = {m_word[23:0], b};
      if (d % 4 == 3) begin
        m_wr = 1'b1;
        m_wa = BASE + 32'(4 * (d / 4));
        m_wd = m_word;
        if (d / 4 == int'(m_n) - 1) finish_data();
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_chk = 1'b0; m_wr = 1'b0; m_stat = 0; m_cnt = 0;
    end else begin
      m_wr = 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy = 1'b1; m_chk = 1'b0; m_stat = 0; m_cnt = 0; m_x = 8'h00;
        end
      end else if (bus.byte_valid) begin
        accept(bus.byte_in);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    check_bit("byte_ready", bus.byte_ready, m_busy);
    check_bit("done", bus.done, !m_busy && (m_stat == 1));
    check_bit("error", bus.error, !m_busy && (m_stat == 2));
    check_bit("cpu_hold", bus.cpu_hold, !(!m_busy && (m_stat == 1)));
    check_bit("wr_en", bus.wr_en, m_wr);
    if (m_wr) begin
      check_val("wr_addr", 64'(bus.wr_addr), 64'(m_wa));
      check_val("wr_data", 64'(bus.wr_data), 64'(m_wd));
    end
    if (bus.wr_en) wlog.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic drive_idle(input int n, input bit garbage);
    repeat (n) begin
      @(negedge clk);
      bus.start      = 1'b0;
      bus.byte_valid = garbage ? 1'($urandom) : 1'b0;
      bus.byte_in    = 8'($urandom);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start      = 1'b1;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Offers one byte after 0..gap_max idle cycles; returns with the transfer due at the next edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit rs);
    int gap;
    int tries;
    gap   = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    tries = 0;
    repeat (gap) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      bus.start      = rs ? ($urandom_range(3, 0) == 0) : 1'b0;
    end
    @(negedge clk);
    bus.start      = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    while (!bus.byte_ready && tries < 16) begin
      @(negedge clk);
      tries++;
    end
    if (tries == 16) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake: byte_ready stayed 0, required 1 at %0t", $time);
      bus.byte_valid = 1'b0;
    end
  endtask

  task automatic send_image(input logic [7:0] s[$], input int gap_max, input bit rs);
    pulse_start();
    foreach (s[i]) send_byte(s[i], gap_max, rs);
    drive_idle(4, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_bit({tag, "_byte_ready"}, bus.byte_ready, 1'b0);
    check_bit({tag, "_wr_en"}, bus.wr_en, 1'b0);
    check_val({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'h0000_0000_FFFF_FFF8);
    check_val({tag, "_wr_data"}, 64'(bus.wr_data), 64'h0);
    check_bit({tag, "_cpu_hold"}, bus.cpu_hold, 1'b1);
    check_bit({tag, "_done"}, bus.done, 1'b0);
    check_bit({tag, "_error"}, bus.error, 1'b0);
  endtask

  task automatic check_wlog(input string tag, input int idx, input logic [63:0] exp);
    if (wlog.size() > idx) check_val(tag, wlog[idx], exp);
    else check_val({tag, "_missing"}, 64'(wlog.size()), 64'(idx + 1));
  endtask

  logic [7:0] t1[$];
  logic [7:0] q[$];

  initial begin
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Image 1: two words. Stream XOR is 8'h57.
    t1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
`ifdef IMEM_LOADER_CHECKSUM_EN
    t1.push_back(8'h57);
`endif
    wlog.delete();
    send_image(t1, 0, 1'b0);
    check_val("t1_count", 64'(wlog.size()), 64'd2);
    check_wlog("t1_w0", 0, 64'hFFFF_FFF8_2008_0005);
    check_wlog("t1_w1", 1, 64'hFFFF_FFFC_0109_5020);
    check_bit("t1_done", bus.done, 1'b1);
    check_bit("t1_cpu_hold", bus.cpu_hold, 1'b0);

    // Empty image.
    q = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    q.push_back(8'h00);
`endif
    wlog.delete();
    send_image(q, 0, 1'b0);
    check_val("t2_count", 64'(wlog.size()), 64'd0);
    check_bit("t2_done", bus.done, 1'b1);

    // Over-length header, stray valid bytes while rejected, then a one-word reload.
    wlog.delete();
    q = '{8'h00, 8'h05};
    send_image(q, 0, 1'b0);
    drive_idle(4, 1'b1);
    check_bit("t3_error", bus.error, 1'b1);
    check_bit("t3_cpu_hold", bus.cpu_hold, 1'b1);
    check_bit("t3_byte_ready", bus.byte_ready, 1'b0);
    check_val("t3_count", 64'(wlog.size()), 64'd0);
    q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    q.push_back(8'h01);
`endif
    send_image(q, 0, 1'b0);
    check_bit("t3b_done", bus.done, 1'b1);
    check_val("t3b_count", 64'(wlog.size()), 64'd1);
    check_wlog("t3b_w0", 0, 64'hFFFF_FFF8_AABB_CCDD);

    // Image 1 again with random gaps and stray start pulses mid-load.
    wlog.delete();
    send_image(t1, 5, 1'b1);
    check_val("t4_count", 64'(wlog.size()), 64'd2);
    check_wlog("t4_w0", 0, 64'hFFFF_FFF8_2008_0005);
    check_wlog("t4_w1", 1, 64'hFFFF_FFFC_0109_5020);
    check_bit("t4_done", bus.done, 1'b1);

    // Asynchronous reset after six data bytes, then a fresh load.
    q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    pulse_start();
    foreach (q[i]) send_byte(q[i], 0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("t5_async");
    bus.byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wlog.delete();
    q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
    q.push_back(8'h23);
`endif
    send_image(q, 0, 1'b0);
    check_val("t5_count", 64'(wlog.size()), 64'd1);
    check_wlog("t5_w0", 0, 64'hFFFF_FFF8_DEAD_BEEF);
    check_bit("t5_done", bus.done, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: image rejected but its words stay written.
    q = t1;
    q[q.size() - 1] = 8'h00;
    wlog.delete();
    send_image(q, 0, 1'b0);
    check_bit("t6_error", bus.error, 1'b1);
    check_bit("t6_cpu_hold", bus.cpu_hold, 1'b1);
    check_val("t6_count", 64'(wlog.size()), 64'd2);
`endif

    // Randomized images, checked by the model every cycle.
    for (int it = 0; it < 40; it++) begin
      logic [15:0] n;
      logic [7:0]  x;
      n = 16'($urandom_range(6, 0));
      if ($urandom_range(7, 0) == 0) n = n | 16'h0100;
      q = '{n[15:8], n[7:0]};
      if (32'(n) <= MAXW) begin
        for (int k = 0; k < 4 * int'(n); k++) q.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (q[j]) x = x ^ q[j];
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        q.push_back(x);
`endif
      end
      send_image(q, 3, 1'($urandom));
      drive_idle(int'($urandom_range(4, 1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
